fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage that owns the program counter and drives the byte address into the combinational instruction memory.
- Captures the returned 32-bit instruction, with its PC, into the IF/ID pipeline register for the decoder.
- Handles sequential increment, branch/jump redirect with flush, decode stall, and out-of-range fetch detection.
- Sits between the decode/execute redirect logic and the instruction memory.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_WORDS, 100, instruction memory depth in 32-bit words; valid byte addresses are 0 to 4*IMEM_WORDS-1.
- NOP_INSTR, 32'h0000_0000, encoding inserted into IF/ID on bubble or flush.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pc  out  32  fetch byte address to instruction memory.
- instr_in  in  32  instruction returned combinationally for the current pc.
- stall  in  1  decode hazard; hold PC and IF/ID.
- branch_taken  in  1  branch resolved taken this cycle.
- branch_pc  in  32  PC of the branching instruction.
- branch_offset  in  16  signed word offset.
- jump_en  in  1  jump resolved this cycle.
- jump_pc  in  32  PC of the jump instruction.
- jump_index  in  26  word index field.
- if_pc  out  32  PC of the instruction held in IF/ID.
- if_instr  out  32  instruction held in IF/ID.
- if_valid  out  1  IF/ID holds a real instruction.
- addr_err  out  1  one-cycle pulse: fetch attempted at an out-of-range or misaligned pc.
- fetch_count  out  32  number of valid instructions written into IF/ID.

Behaviour:
- Reset (rst_n low, asynchronous): pc=RESET_PC, if_pc=0, if_instr=NOP_INSTR, if_valid=0, addr_err=0, fetch_count=0. Asserting reset mid-operation discards any redirect or stall immediately.
- Arithmetic, all 32-bit modulo 2^32 with no carry out:
  - pc_plus4 = pc+4.
  - branch_target = branch_pc + 4 + (sign_extend(branch_offset) << 2).
  - jump_target = {jump_pc_plus4[31:28], jump_index, 2'b00}.
  - Wrap from 32'hFFFF_FFFC to 0 is legal.
- Per-cycle priority, evaluated at the rising edge: reset > branch_taken > jump_en > stall > normal.
- Normal (no stall, no redirect):
  - pc <= pc_plus4; if_pc <= pc.
  - If pc is in range and word-aligned: if_instr <= instr_in, if_valid <= 1, fetch_count += 1.
  - Otherwise: if_instr <= NOP_INSTR, if_valid <= 0, addr_err <= 1.
- Redirect (branch_taken or jump_en):
  - pc <= selected target.
  - IF/ID flushed: if_instr <= NOP_INSTR, if_valid <= 0, fetch_count unchanged.
  - Redirect overrides stall.
  - If branch_taken and jump_en are asserted together, branch_taken wins because it comes from the older instruction.
- Stall without redirect: pc, if_pc, if_instr, if_valid and fetch_count are all held; addr_err <= 0.
- addr_err is registered, high for exactly one cycle per offending fetch, and deasserted otherwise.
- A target with nonzero bits [1:0] is loaded unmodified; the following fetch flags addr_err and produces a bubble.
- Latency: an instruction at pc appears on if_instr one cycle later. A redirect costs one bubble cycle.
- The instruction memory must be combinational (read in the same cycle); no instruction-memory handshake exists.

Decomposition:
- Shared package `cpu_pkg`: XLEN=32, NOP_INSTR, RESET_PC, and the width constants BR_OFF_W=16 and J_IDX_W=26.
- One sub-module, `next_pc_calc`: purely combinational; computes pc_plus4, branch_target, jump_target and the priority-selected next_pc. The sequential registers stay in fetch_unit.

Test Plan:
- Reset, then free-run 4 cycles with memory words 0..3 = 0, 01098020, 3510003D, 8E680028 -> pc steps 0,4,8,12,16; if_instr lags one cycle; fetch_count=4.
- branch_taken with branch_pc=0x10 and branch_offset=0x0006 -> next pc=0x2C; following cycle if_valid=0 and if_instr=0; the fetch after that loads word 11.
- jump_en with jump_pc=0x14 and jump_index=0x1C -> next pc=0x70; one bubble; then if_instr=014C9820 and if_pc=0x70.
- stall held 3 cycles at pc=8 -> pc, if_pc and if_instr frozen, fetch_count frozen; branch_taken raised during the stall still redirects.
- branch_taken and jump_en together (branch target 0x40, jump target 0x70) -> pc=0x40; branch_offset=0xFFFF with branch_pc=0x8 -> target 0x8 (self-loop).
- pc reaches 0x190 (IMEM_WORDS=100) -> addr_err pulses 1 cycle, if_valid=0; a misaligned target of 0x2 gives the same result. Asserting rst_n low mid-stall restores all outputs asynchronously to their reset values.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants and the fetch next-PC source encoding.
package cpu_pkg;
  localparam int XLEN     = 32;
  localparam int BR_OFF_W = 16;
  localparam int J_IDX_W  = 26;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;

  typedef enum logic [1:0] {
    SEL_SEQ  = 2'd0,
    SEL_BR   = 2'd1,
    SEL_JMP  = 2'd2,
    SEL_HOLD = 2'd3
  } npc_sel_e;
endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: branch > jump > stall > sequential.
module next_pc_calc
  import cpu_pkg::*;
(
  input  logic [XLEN-1:0]     pc_i,
  input  logic                stall_i,
  input  logic                branch_taken_i,
  input  logic [XLEN-1:0]     branch_pc_i,
  input  logic [BR_OFF_W-1:0] branch_offset_i,
  input  logic                jump_en_i,
  input  logic [XLEN-1:0]     jump_pc_i,
  input  logic [J_IDX_W-1:0]  jump_index_i,
  output logic [XLEN-1:0]     next_pc_o,
  output npc_sel_e            sel_o
);
  logic [XLEN-1:0] pc_plus4, branch_target, jump_target, br_off_ext;

  assign pc_plus4      = pc_i + 32'd4;
  assign br_off_ext    = {{(XLEN-BR_OFF_W-2){branch_offset_i[BR_OFF_W-1]}}, branch_offset_i, 2'b00};
  assign branch_target = branch_pc_i + 32'd4 + br_off_ext;
  // Region bits come from the jump's own PC+4, not the current fetch PC.
  assign jump_target   = ((jump_pc_i + 32'd4) & 32'hF000_0000) | {4'b0000, jump_index_i, 2'b00};

  always_comb begin
    next_pc_o = pc_plus4;
    sel_o     = SEL_SEQ;
    if (branch_taken_i) begin
      next_pc_o = branch_target;
      sel_o     = SEL_BR;
    end else if (jump_en_i) begin
      next_pc_o = jump_target;
      sel_o     = SEL_JMP;
    end else if (stall_i) begin
      next_pc_o = pc_i;
      sel_o     = SEL_HOLD;
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC and the IF/ID register, flags bad fetches.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = cpu_pkg::RESET_PC,
  parameter int              IMEM_WORDS = 100,
  parameter logic [XLEN-1:0] NOP_INSTR  = cpu_pkg::NOP_INSTR
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [XLEN-1:0]     pc,
  input  logic [XLEN-1:0]     instr_in,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [XLEN-1:0]     branch_pc,
  input  logic [BR_OFF_W-1:0] branch_offset,
  input  logic                jump_en,
  input  logic [XLEN-1:0]     jump_pc,
  input  logic [J_IDX_W-1:0]  jump_index,
  output logic [XLEN-1:0]     if_pc,
  output logic [XLEN-1:0]     if_instr,
  output logic                if_valid,
  output logic                addr_err,
  output logic [XLEN-1:0]     fetch_count
);
  localparam logic [XLEN-1:0] IMEM_BYTES = XLEN'(4 * IMEM_WORDS);

  logic [XLEN-1:0] pc_q, pc_d, if_pc_q, if_pc_d, if_instr_q, if_instr_d, cnt_q, cnt_d;
  logic            if_valid_q, if_valid_d, addr_err_q, addr_err_d;
  logic [XLEN-1:0] next_pc;
  npc_sel_e        sel;
  logic            fetch_ok;

  next_pc_calc u_npc (
    .pc_i            (pc_q),
    .stall_i         (stall),
    .branch_taken_i  (branch_taken),
    .branch_pc_i     (branch_pc),
    .branch_offset_i (branch_offset),
    .jump_en_i       (jump_en),
    .jump_pc_i       (jump_pc),
    .jump_index_i    (jump_index),
    .next_pc_o       (next_pc),
    .sel_o           (sel)
  );

  assign fetch_ok = (pc_q[1:0] == 2'b00) && (pc_q < IMEM_BYTES);

  always_comb begin
    pc_d       = next_pc;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    if_valid_d = if_valid_q;
    addr_err_d = 1'b0;
    cnt_d      = cnt_q;
    case (sel)
      SEL_BR, SEL_JMP: begin
        if_instr_d = NOP_INSTR;
        if_valid_d = 1'b0;
      end
      SEL_HOLD: ;
      default: begin
        if_pc_d = pc_q;
        if (fetch_ok) begin
          if_instr_d = instr_in;
          if_valid_d = 1'b1;
          cnt_d      = cnt_q + 32'd1;
        end else begin
          if_instr_d = NOP_INSTR;
          if_valid_d = 1'b0;
          addr_err_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      if_pc_q    <= '0;
      if_instr_q <= NOP_INSTR;
      if_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      if_valid_q <= if_valid_d;
      addr_err_q <= addr_err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign pc          = pc_q;
  assign if_pc       = if_pc_q;
  assign if_instr    = if_instr_q;
  assign if_valid    = if_valid_q;
  assign addr_err    = addr_err_q;
  assign fetch_count = cnt_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a small combinational instruction memory.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc, instr_in, branch_pc, jump_pc, if_pc, if_instr, fetch_count;
  logic        stall, branch_taken, jump_en, if_valid, addr_err;
  logic [15:0] branch_offset;
  logic [25:0] jump_index;
  logic [31:0] imem [0:99];
  int          n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  assign instr_in = (pc < 32'd400) ? imem[pc[8:2]] : 32'hDEAD_BEEF;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .instr_in(instr_in), .stall(stall),
    .branch_taken(branch_taken), .branch_pc(branch_pc), .branch_offset(branch_offset),
    .jump_en(jump_en), .jump_pc(jump_pc), .jump_index(jump_index),
    .if_pc(if_pc), .if_instr(if_instr), .if_valid(if_valid), .addr_err(addr_err),
    .fetch_count(fetch_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; branch_taken = 0; jump_en = 0;
  endtask

  task automatic st(input string tag, input logic [31:0] e_pc, input logic [31:0] e_ifpc,
                    input logic [31:0] e_instr, input logic e_vld, input logic e_err,
                    input logic [31:0] e_cnt);
    chk({tag, ".pc"},    pc,          e_pc);
    chk({tag, ".ifpc"},  if_pc,       e_ifpc);
    chk({tag, ".instr"}, if_instr,    e_instr);
    chk({tag, ".vld"},   {31'd0, if_valid}, {31'd0, e_vld});
    chk({tag, ".err"},   {31'd0, addr_err}, {31'd0, e_err});
    chk({tag, ".cnt"},   fetch_count, e_cnt);
  endtask

  task automatic do_jump(input logic [31:0] jpc, input logic [25:0] idx);
    idle(); jump_en = 1; jump_pc = jpc; jump_index = idx;
  endtask

  initial begin
    for (int i = 0; i < 100; i++) imem[i] = 32'hA000_0000 | i;
    imem[0] = 32'h0000_0000; imem[1] = 32'h0109_8020;
    imem[2] = 32'h3510_003D; imem[3] = 32'h8E68_0028;
    imem[11] = 32'h8C0B_0004; imem[28] = 32'h014C_9820;
    rst_n = 0; idle(); branch_pc = 0; branch_offset = 0; jump_pc = 0; jump_index = 0;
    #12;
    st("reset", 32'h0, 32'h0, 32'h0, 0, 0, 0);
    @(negedge clk); rst_n = 1;

    step(); st("seq1", 32'h04, 32'h00, 32'h0000_0000, 1, 0, 1);
    step(); st("seq2", 32'h08, 32'h04, 32'h0109_8020, 1, 0, 2);
    step(); st("seq3", 32'h0C, 32'h08, 32'h3510_003D, 1, 0, 3);
    step(); st("seq4", 32'h10, 32'h0C, 32'h8E68_0028, 1, 0, 4);

    branch_taken = 1; branch_pc = 32'h10; branch_offset = 16'h0006;
    step(); st("br",      32'h2C, 32'h0C, 32'h0, 0, 0, 4);
    idle();
    step(); st("br_next", 32'h30, 32'h2C, 32'h8C0B_0004, 1, 0, 5);

    do_jump(32'h14, 26'h1C);
    step(); st("jmp",      32'h70, 32'h2C, 32'h0, 0, 0, 5);
    idle();
    step(); st("jmp_next", 32'h74, 32'h70, 32'h014C_9820, 1, 0, 6);

    do_jump(32'h0, 26'h1);
    step(); chk("j4.pc", pc, 32'h04);
    idle();
    step(); st("pre_stall", 32'h08, 32'h04, 32'h0109_8020, 1, 0, 7);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step(); st("stall", 32'h08, 32'h04, 32'h0109_8020, 1, 0, 7);
    end
    // Branch and jump together while stalled: branch must win.
    branch_taken = 1; branch_pc = 32'h30; branch_offset = 16'h0003;
    jump_en = 1; jump_pc = 32'h14; jump_index = 26'h1C;
    step(); st("br_jmp_stall", 32'h40, 32'h04, 32'h0, 0, 0, 7);
    idle(); branch_taken = 1; branch_pc = 32'h8; branch_offset = 16'hFFFF;
    step(); chk("selfloop.pc", pc, 32'h08);
    idle();
    step(); st("after_loop", 32'h0C, 32'h08, 32'h3510_003D, 1, 0, 8);

    do_jump(32'h0, 26'h64);
    step(); chk("oor.pc", pc, 32'h190);
    idle();
    step(); st("oor_err", 32'h194, 32'h190, 32'h0, 0, 1, 8);
    do_jump(32'h0, 26'h0);
    step(); st("oor_clear", 32'h0, 32'h190, 32'h0, 0, 0, 8);

    idle(); branch_taken = 1; branch_pc = 32'hFFFF_FFFE; branch_offset = 16'h0000;
    step(); chk("mis.pc", pc, 32'h2);
    idle();
    step(); st("mis_err", 32'h6, 32'h2, 32'h0, 0, 1, 8);
    do_jump(32'h0, 26'h0);
    step(); st("mis_clear", 32'h0, 32'h2, 32'h0, 0, 0, 8);
    idle();
    step(); st("resume1", 32'h4, 32'h0, 32'h0, 1, 0, 9);
    step(); st("resume2", 32'h8, 32'h4, 32'h0109_8020, 1, 0, 10);

    stall = 1; branch_taken = 0;
    step(); st("stall2", 32'h8, 32'h4, 32'h0109_8020, 1, 0, 10);
    #2 rst_n = 0;
    #1 st("async_rst", 32'h0, 32'h0, 32'h0, 0, 0, 0);
    step(); st("rst_hold", 32'h0, 32'h0, 32'h0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
